alu_writeback_stage: RTL and testbench
======================================

Name: alu_writeback_stage

Overview:
- Registered stage directly downstream of the ADD/SUB/MUL/CMP arithmetic units.
- Each cycle it can accept one opcode-tagged operation, select the matching result and 4-bit flag vector, and buffer it in a 2-entry skid FIFO.
- Drains entries to the register-file write port with a valid/ready handshake.
- Maintains the architectural status (flag) register, updated at commit.

Parameters:
- DATA_W, 16, result width (signed two's complement)
- DEST_W, 3, destination register index width
- DEPTH, 2, skid buffer entries (fixed at 2; other values unsupported)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream operation valid
- in_ready  out  1  stage can accept an operation
- in_op  in  2  00=ADD, 01=SUB, 10=MUL, 11=CMP
- in_dest  in  DEST_W  destination register
- in_sum  in  DATA_W  ADD result
- in_dif  in  DATA_W  SUB result
- in_mul  in  DATA_W  MUL result
- in_flag_add  in  4  ADD flags
- in_flag_sub  in  4  SUB flags
- in_flag_mul  in  4  MUL flags
- in_flag_cmp  in  4  CMP flags
- out_valid  out  1  write-port entry valid
- out_ready  in  1  register file accepts write
- out_we  out  1  1 for ADD/SUB/MUL; 0 for CMP (flags-only)
- out_dest  out  DEST_W  write index
- out_data  out  DATA_W  write data
- status  out  4  architectural flags {N,Z,C,V}, bit3..bit0

Behaviour:
- Flag order is decided: [3]=N, [2]=Z, [1]=C, [0]=V.
- Reset (rst_n=0 at clk edge): buffer emptied (count=0).
  - in_ready=0 during reset, 1 from the first cycle after release.
  - out_valid=0, out_we=0, out_dest=0, out_data=0, status=4'b0000.
- Accept: in_valid & in_ready at a clk edge pushes {op-selected data, op-selected flags, in_dest, we = (in_op!=CMP)}.
  - CMP pushes data=0.
- Commit: out_valid & out_ready at a clk edge pops the head entry, and status <= head flags in that same edge.
- Latency: accepted op appears on out_* the cycle after acceptance (1 cycle); status changes the edge the entry commits.
- State machine on occupancy:
  - EMPTY: push -> ONE.
  - ONE: push only -> TWO; pop only -> EMPTY; push and pop together -> ONE, with the new entry becoming head next cycle.
  - TWO: pop -> ONE; push impossible.
- in_ready = (count != 2), registered (no combinational path from out_ready to in_ready).
- out_valid = (count != 0); out_* always reflect the head entry and are held stable while out_valid & !out_ready.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Flags are passed through unmodified from the selected unit. The stage does not recompute arithmetic; widths are DATA_W throughout with no extension.
- Reset mid-operation discards both entries; status is not updated by discarded entries.
- in_* values are ignored when in_valid=0 or in_ready=0.

Optional Feature:
- Macro: ALU_WB_STICKY_OVF_EN
- Defined: status[0] (V) is sticky.
  - On commit, V <= V | head_V; N, Z, C update normally.
  - Sticky V clears only on reset, or on commit of a CMP whose V=0 and whose dest field equals all ones (clear-overflow idiom).
- Undefined: V updates like the other flags; no extra state.

Decomposition:
- Package alu_wb_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_CMP
  - flag bit index constants FLG_N/FLG_Z/FLG_C/FLG_V
  - entry struct {we, dest, data, flags}
- Sub-module alu_wb_skid: generic 2-entry valid/ready skid buffer parameterised on payload width. Instantiated once; the top keeps opcode select and status register.

Test Plan:
- ADD 10+15: in_op=00, sum=25, flag_add=0000, dest=1, out_ready=1 -> next cycle out_valid=1, out_we=1, out_data=25, out_dest=1; status=0000 after commit.
- SUB 25-(-30): in_op=01, dif=55, flag_sub=0000 -> out_data=55; then MUL 25*25 with mul=625 -> out_data=625, order preserved.
- CMP -25 vs -30: in_op=11, flag_cmp=0000, then CMP 25 vs 25 with flag_cmp=0100 -> out_we=0, out_data=0; status=0100 after the second commit.
- Backpressure: out_ready=0, push 3 ops back-to-back -> in_ready=0 after the 2nd accept, 3rd held; outputs stable. Then out_ready=1 -> all three drain in order, one per cycle.
- Reset mid-operation: two entries buffered, rst_n=0 one cycle -> out_valid=0, status=0000, in_ready=1 the cycle after release; no stale write appears.
- ALU_WB_STICKY_OVF_EN defined: commit flags 0001, then 0000 -> status[0] stays 1. With the macro undefined, status[0]=0 after the second commit.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// Shared opcode, flag-index and buffer-entry definitions for the ALU writeback stage.
package alu_wb_pkg;

    localparam int unsigned WB_DATA_W = 16;
    localparam int unsigned WB_DEST_W = 3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    typedef struct packed {
        logic                 we;
        logic [WB_DEST_W-1:0] dest;
        logic [WB_DATA_W-1:0] data;
        logic [3:0]           flags;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready is a registered output.
module alu_wb_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    occ_t         state, next_state;
    logic [W-1:0] head, tail;
    logic         ready_q;
    logic         push, pop;
    logic         load_head, load_tail, head_from_tail;

    assign push      = in_valid & ready_q;
    assign out_valid = (state != EMPTY);
    assign pop       = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign out_data  = head;

    always_comb begin
        next_state     = state;
        load_head      = 1'b0;
        load_tail      = 1'b0;
        head_from_tail = 1'b0;
        case (state)
            EMPTY: if (push) begin
                next_state = ONE;
                load_head  = 1'b1;
            end
            ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    next_state = TWO;
                    load_tail  = 1'b1;
                end else if (pop) begin
                    next_state = EMPTY;
                end
            end
            TWO: if (pop) begin
                next_state     = ONE;
                head_from_tail = 1'b1;
            end
            default: next_state = EMPTY;
        endcase
    end

    // Ready is computed from the next occupancy so it lands in a flop, keeping out_ready off any in_ready path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            head    <= '0;
            tail    <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != TWO);
            if (load_head)
                head <= in_data;
            else if (head_from_tail)
                head <= tail;
            if (load_tail)
                tail <= in_data;
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: opcode result/flag select, 2-entry skid buffer, status register at commit.
// Optional ALU_WB_STICKY_OVF_EN makes status V sticky (cleared by reset or CMP-to-all-ones with V=0).
module alu_writeback_stage
    import alu_wb_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned DEST_W = WB_DEST_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_sum,
    input  logic [DATA_W-1:0] in_dif,
    input  logic [DATA_W-1:0] in_mul,
    input  logic [3:0]        in_flag_add,
    input  logic [3:0]        in_flag_sub,
    input  logic [3:0]        in_flag_mul,
    input  logic [3:0]        in_flag_cmp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        status
);

    localparam int unsigned EW = $bits(wb_entry_t);

    wb_entry_t  push_entry, head;
    logic       commit;
    logic [3:0] next_status;

    always_comb begin
        push_entry      = '0;
        push_entry.dest = in_dest;
        push_entry.we   = (in_op != OP_CMP);
        case (in_op)
            OP_ADD: begin push_entry.data = in_sum; push_entry.flags = in_flag_add; end
            OP_SUB: begin push_entry.data = in_dif; push_entry.flags = in_flag_sub; end
            OP_MUL: begin push_entry.data = in_mul; push_entry.flags = in_flag_mul; end
            default: begin push_entry.data = '0;    push_entry.flags = in_flag_cmp; end
        endcase
    end

    alu_wb_skid #(.W(EW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (push_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_we   = head.we;
    assign out_dest = head.dest;
    assign out_data = head.data;
    assign commit   = out_valid & out_ready;

    always_comb begin
        next_status = head.flags;
`ifdef ALU_WB_STICKY_OVF_EN
        if (!head.we && !head.flags[FLG_V] && (&head.dest))
            next_status[FLG_V] = 1'b0;
        else
            next_status[FLG_V] = status[FLG_V] | head.flags[FLG_V];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            status <= '0;
        else if (commit)
            status <= next_status;
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [2:0]  in_dest;
    logic [15:0] in_sum, in_dif, in_mul;
    logic [3:0]  in_flag_add, in_flag_sub, in_flag_mul, in_flag_cmp;
    logic        out_valid;
    logic        out_ready;
    logic        out_we;
    logic [2:0]  out_dest;
    logic [15:0] out_data;
    logic [3:0]  status;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    alu_writeback_stage #(.DATA_W(16), .DEST_W(3), .DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_dest     (in_dest),
        .in_sum      (in_sum),
        .in_dif      (in_dif),
        .in_mul      (in_mul),
        .in_flag_add (in_flag_add),
        .in_flag_sub (in_flag_sub),
        .in_flag_mul (in_flag_mul),
        .in_flag_cmp (in_flag_cmp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_we      (out_we),
        .out_dest    (out_dest),
        .out_data    (out_data),
        .status      (status)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation; unselected units carry distractor values.
    task automatic drive(input logic [1:0] op, input logic [2:0] dest,
                         input logic [15:0] val, input logic [3:0] flg);
        in_valid    = 1'b1;
        in_op       = op;
        in_dest     = dest;
        in_sum      = 16'hAAAA;
        in_dif      = 16'hBBBB;
        in_mul      = 16'hCCCC;
        in_flag_add = 4'b1111;
        in_flag_sub = 4'b1111;
        in_flag_mul = 4'b1111;
        in_flag_cmp = 4'b1111;
        case (op)
            2'b00: begin in_sum = val; in_flag_add = flg; end
            2'b01: begin in_dif = val; in_flag_sub = flg; end
            2'b10: begin in_mul = val; in_flag_mul = flg; end
            default: in_flag_cmp = flg;
        endcase
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(2'b00, 3'd0, 16'd0, 4'b0000);
        in_valid  = 1'b0;
        step();
        step();
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_we",    out_we,    0);
        chk("rst_out_dest",  out_dest,  0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_status",    status,    0);

        rst_n = 1'b1;
        step();
        chk("rel_in_ready", in_ready, 1);

        // ADD 10+15
        drive(2'b00, 3'd1, 16'd25, 4'b0000);
        step();
        in_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_we",    out_we,    1);
        chk("add_data",  out_data,  25);
        chk("add_dest",  out_dest,  1);
        step();
        chk("add_drained", out_valid, 0);
        chk("add_status",  status,    4'b0000);

        // SUB then MUL back-to-back (push and pop together in ONE)
        drive(2'b01, 3'd2, 16'd55, 4'b0000);
        step();
        chk("sub_data", out_data, 55);
        chk("sub_dest", out_dest, 2);
        drive(2'b10, 3'd3, 16'd625, 4'b0000);
        step();
        in_valid = 1'b0;
        chk("mul_data",  out_data,  625);
        chk("mul_dest",  out_dest,  3);
        chk("mul_valid", out_valid, 1);
        step();
        chk("mul_drained", out_valid, 0);

        // CMP pair
        drive(2'b11, 3'd4, 16'd0, 4'b0000);
        step();
        chk("cmp1_we",   out_we,   0);
        chk("cmp1_data", out_data, 0);
        drive(2'b11, 3'd5, 16'd0, 4'b0100);
        step();
        in_valid = 1'b0;
        chk("cmp1_status", status, 4'b0000);
        chk("cmp2_we",     out_we,   0);
        chk("cmp2_data",   out_data, 0);
        step();
        chk("cmp2_status", status, 4'b0100);

        // Backpressure: three pushes, third held
        out_ready = 1'b0;
        drive(2'b00, 3'd4, 16'd100, 4'b1000);
        step();
        chk("bp_ready1", in_ready, 1);
        chk("bp_head1",  out_data, 100);
        drive(2'b01, 3'd5, 16'd200, 4'b0010);
        step();
        chk("bp_ready2", in_ready, 0);
        chk("bp_head2",  out_data, 100);
        drive(2'b10, 3'd6, 16'd300, 4'b0001);
        step();
        chk("bp_held_ready", in_ready, 0);
        chk("bp_held_data",  out_data, 100);
        chk("bp_held_dest",  out_dest, 4);
        chk("bp_status",     status,   4'b0100);
        out_ready = 1'b1;
        step();
        chk("bp_drain_b",  out_data, 200);
        chk("bp_status_a", status,   4'b1000);
        chk("bp_ready3",   in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_drain_c",  out_data, 300);
        chk("bp_dest_c",   out_dest, 6);
        chk("bp_status_b", status,   4'b0010);
        step();
        chk("bp_empty",    out_valid, 0);
        chk("bp_status_c", status,    4'b0001);

        // Reset with two entries buffered
        out_ready = 1'b0;
        drive(2'b00, 3'd1, 16'd11, 4'b1111);
        step();
        drive(2'b00, 3'd2, 16'd22, 4'b1111);
        step();
        in_valid = 1'b0;
        chk("mr_full", in_ready, 0);
        rst_n = 1'b0;
        step();
        chk("mr_valid",  out_valid, 0);
        chk("mr_status", status,    0);
        chk("mr_ready",  in_ready,  0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mr_rel_ready",  in_ready,  1);
        chk("mr_rel_valid",  out_valid, 0);
        step();
        chk("mr_no_stale",   out_valid, 0);
        chk("mr_rel_status", status,    0);

        // Overflow stickiness
        drive(2'b00, 3'd1, 16'd1, 4'b0001);
        step();
        drive(2'b00, 3'd2, 16'd2, 4'b0000);
        step();
        in_valid = 1'b0;
        chk("ovf_first", status, 4'b0001);
        step();
`ifdef ALU_WB_STICKY_OVF_EN
        chk("ovf_sticky", status, 4'b0001);
`else
        chk("ovf_plain", status, 4'b0000);
`endif
        drive(2'b11, 3'd7, 16'd0, 4'b0000);
        step();
        in_valid = 1'b0;
        step();
        chk("ovf_clear", status, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
